// File: rtl/issue_stage_b.sv
// issue_stage_b
// Decode/issue stage for superscalar lane B. It decodes a fetched instruction
// into the execute type code and reads the register file. It sign-extends the
// immediate, then loads everything into the ID/EX pipeline register under a
// valid/ready handshake.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : fetch-side handshake
//   in_ir, in_pc      : instruction word and its PC
//   rs1_addr/rs2_addr : register file read addresses (combinational)
//   rf_rdata1/2       : register file read data for those addresses
//   a_dst_valid/a_dst : older lane-A destination in the same bundle
//   ex_load_valid/dst : load currently in EX and its destination
//   out_valid/ready   : execute-side handshake
//   out_a/b/pc/ir/imm : registered operands and payload
//   out_type          : 3-bit execute type code
//   out_rd/out_wen    : destination register and its write enable
//   out_illegal       : only when ILLEGAL_OP_TRAP_EN is defined
//
// Optional feature macro: ILLEGAL_OP_TRAP_EN
//   Defined  : unknown opcodes (other than 111111) raise out_illegal. Once such
//              an instruction is accepted, the stage stops accepting until reset.
//   Undefined: unknown opcodes decode silently as NOP.
module issue_stage_b #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_ir,
  input  logic [XLEN-1:0]    in_pc,
  output logic [RADDR_W-1:0] rs1_addr,
  output logic [RADDR_W-1:0] rs2_addr,
  input  logic [XLEN-1:0]    rf_rdata1,
  input  logic [XLEN-1:0]    rf_rdata2,
  input  logic               a_dst_valid,
  input  logic [RADDR_W-1:0] a_dst,
  input  logic               ex_load_valid,
  input  logic [RADDR_W-1:0] ex_load_dst,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_a,
  output logic [XLEN-1:0]    out_b,
  output logic [XLEN-1:0]    out_pc,
  output logic [XLEN-1:0]    out_ir,
  output logic [XLEN-1:0]    out_imm,
  output logic [2:0]         out_type,
  output logic [RADDR_W-1:0] out_rd,
  output logic               out_wen
`ifdef ILLEGAL_OP_TRAP_EN
  ,
  output logic               out_illegal
`endif
);

  typedef enum logic [2:0] {
    TYPE_RR    = 3'b000,
    TYPE_RI    = 3'b001,
    TYPE_LOAD  = 3'b010,
    TYPE_STORE = 3'b011,
    TYPE_NOP   = 3'b111
  } exec_type_e;

  logic [5:0]         opcode;
  logic [RADDR_W-1:0] rd_field;
  exec_type_e         dec_type;
  logic               use_rs1;
  logic               use_rs2;
  logic               hazard;
  logic               dec_wen;
  logic [XLEN-1:0]    dec_imm;
  logic               accept;
  logic               stop_accept;

  logic               valid_q, valid_d;
  logic [XLEN-1:0]    a_q, a_d;
  logic [XLEN-1:0]    b_q, b_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    ir_q, ir_d;
  logic [XLEN-1:0]    imm_q, imm_d;
  exec_type_e         type_q, type_d;
  logic [RADDR_W-1:0] rd_q, rd_d;
  logic               wen_q, wen_d;

  assign opcode   = in_ir[31:26];
  assign rd_field = in_ir[25:21];

  // Opcode to execute type. Anything outside the known ranges becomes NOP.
  always_comb begin
    dec_type = TYPE_NOP;
    if (opcode <= 6'd7) begin
      dec_type = TYPE_RR;
    end else if ((opcode >= 6'd8) && (opcode <= 6'd12)) begin
      dec_type = TYPE_RI;
    end else if (opcode == 6'd16) begin
      dec_type = TYPE_LOAD;
    end else if (opcode == 6'd17) begin
      dec_type = TYPE_STORE;
    end
  end

  // A store sources its data from the rd field, so it goes out on read port 2.
  always_comb begin
    rs2_addr = '0;
    if (dec_type == TYPE_RR) begin
      rs2_addr = in_ir[15:11];
    end else if (dec_type == TYPE_STORE) begin
      rs2_addr = rd_field;
    end
  end

  assign rs1_addr = in_ir[20:16];
  assign use_rs1  = (dec_type != TYPE_NOP);
  assign use_rs2  = (dec_type == TYPE_RR) || (dec_type == TYPE_STORE);

  function automatic logic src_blocked(input logic [RADDR_W-1:0] src,
                                       input logic a_v, input logic [RADDR_W-1:0] a_d_in,
                                       input logic l_v, input logic [RADDR_W-1:0] l_d);
    return (src != '0) && ((a_v && (src == a_d_in)) || (l_v && (src == l_d)));
  endfunction

  assign hazard = (use_rs1 && src_blocked(rs1_addr, a_dst_valid, a_dst, ex_load_valid, ex_load_dst)) ||
                  (use_rs2 && src_blocked(rs2_addr, a_dst_valid, a_dst, ex_load_valid, ex_load_dst));

  assign dec_wen = ((dec_type == TYPE_RR) || (dec_type == TYPE_RI) || (dec_type == TYPE_LOAD)) &&
                   (rd_field != '0);
  assign dec_imm = ((dec_type == TYPE_RR) || (dec_type == TYPE_NOP)) ? '0 :
                   {{(XLEN-16){in_ir[15]}}, in_ir[15:0]};

`ifdef ILLEGAL_OP_TRAP_EN
  logic dec_illegal;
  logic illegal_q, illegal_d;
  logic trap_q, trap_d;

  // NOP decode comes either from 111111 or from an unknown opcode.
  assign dec_illegal = (dec_type == TYPE_NOP) && (opcode != 6'h3F);
  assign stop_accept = trap_q;
  assign out_illegal = illegal_q;
`else
  assign stop_accept = 1'b0;
`endif

  // in_ready is held low during the reset cycle so nothing slips past reset.
  assign in_ready = !rst && (!valid_q || out_ready) && !hazard && !stop_accept;
  assign accept   = in_valid && in_ready;

  // Next state: load on accept, bubble when consumed with nothing new,
  // otherwise hold. Payload never changes on a bubble.
  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    type_d  = type_q;
    rd_d    = rd_q;
    wen_d   = wen_q;
`ifdef ILLEGAL_OP_TRAP_EN
    illegal_d = illegal_q;
    trap_d    = trap_q;
`endif
    if (accept) begin
      valid_d = 1'b1;
      a_d     = rf_rdata1;
      b_d     = rf_rdata2;
      pc_d    = in_pc;
      ir_d    = in_ir;
      imm_d   = dec_imm;
      type_d  = dec_type;
      rd_d    = rd_field;
      wen_d   = dec_wen;
`ifdef ILLEGAL_OP_TRAP_EN
      illegal_d = dec_illegal;
      trap_d    = trap_q || dec_illegal;
`endif
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      pc_q    <= '0;
      ir_q    <= '0;
      imm_q   <= '0;
      type_q  <= TYPE_NOP;
      rd_q    <= '0;
      wen_q   <= 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
      illegal_q <= 1'b0;
      trap_q    <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
      type_q  <= type_d;
      rd_q    <= rd_d;
      wen_q   <= wen_d;
`ifdef ILLEGAL_OP_TRAP_EN
      illegal_q <= illegal_d;
      trap_q    <= trap_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_pc    = pc_q;
  assign out_ir    = ir_q;
  assign out_imm   = imm_q;
  assign out_type  = type_q;
  assign out_rd    = rd_q;
  assign out_wen   = wen_q;

endmodule
